// File: rtl/tx_queue.sv
// Byte FIFO in front of the UART transmit frontend: launches one byte per frame
// as a single-cycle transmit_o pulse, then holds off until the frontend reports done_i.
module tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_i,
    input  logic [7:0]             wr_data_i,
    input  logic                   flush_i,
    input  logic                   overflow_clr_i,
    input  logic                   done_i,
    output logic                   transmit_o,
    output logic [7:0]             dr_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic                   busy_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = LVL_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       mem [DEPTH];
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [LVL_W-1:0] wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_d;
    logic [LVL_W-1:0] level_d;
    logic             push;
    logic             drop;
    logic             launch;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_o && !flush_i) begin
                    launch  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush takes priority over both push and launch; a full queue drops even if a pop lands
    always_comb begin
        push     = wr_i && !full_o && !flush_i;
        drop     = wr_i && full_o && !flush_i;
        wr_ptr_d = push ? wr_ptr + LVL_W'(1) : wr_ptr;
        if (flush_i) begin
            rd_ptr_d = wr_ptr;
        end else if (launch) begin
            rd_ptr_d = rd_ptr + LVL_W'(1);
        end else begin
            rd_ptr_d = rd_ptr;
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            full_o     <= 1'b0;
            empty_o    <= 1'b1;
            transmit_o <= 1'b0;
            dr_o       <= '0;
            overflow_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            level_o    <= level_d;
            full_o     <= (level_d == LVL_W'(DEPTH));
            empty_o    <= (level_d == '0);
            transmit_o <= launch;
            if (launch) begin
                dr_o <= mem[rd_ptr[IDX_W-1:0]];
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data_i;
        end
    end

    assign busy_o = (state_q == WAIT);

endmodule

// File: tb/tb_tx_queue.sv
// Directed bench for tx_queue: a behavioural model plus a byte scoreboard is
// stepped every cycle and compared against all DUT outputs.
module tb_tx_queue;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = '0;
    logic       flush = 1'b0;
    logic       oclr = 1'b0;
    logic       done = 1'b0;
    logic       transmit;
    logic [7:0] dr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         tx_count = 0;

    logic [7:0] sb[$];
    int         m_level = 0;
    logic       m_wait = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_dr = '0;

    tx_queue #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_i           (wr),
        .wr_data_i      (wr_data),
        .flush_i        (flush),
        .overflow_clr_i (oclr),
        .done_i         (done),
        .transmit_o     (transmit),
        .dr_o           (dr),
        .full_o         (full),
        .empty_o        (empty),
        .level_o        (level),
        .overflow_o     (overflow),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge
    task automatic cyc(input logic w, input logic [7:0] d, input logic f,
                       input logic c, input logic dn);
        logic push;
        logic drop;
        logic launch;
        wr = w; wr_data = d; flush = f; oclr = c; done = dn;
        launch = 1'b0;
        if (!rst_n) begin
            m_level = 0; m_wait = 1'b0; m_ovf = 1'b0; m_dr = '0;
            sb.delete();
        end else begin
            push   = w && (m_level < DEPTH) && !f;
            drop   = w && (m_level == DEPTH) && !f;
            launch = !m_wait && (m_level != 0) && !f;
            if (f) begin
                sb.delete();
                m_level = 0;
            end else begin
                if (push) sb.push_back(d);
                m_level = m_level + int'(push) - int'(launch);
            end
            if (launch) m_wait = 1'b1;
            else if (m_wait && dn) m_wait = 1'b0;
            if (drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("transmit", {31'd0, transmit}, {31'd0, launch});
        if (transmit === 1'b1) begin
            tx_count++;
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else m_dr = sb.pop_front();
        end
        chk("dr", {24'd0, dr}, {24'd0, m_dr});
        chk("level", {27'd0, level}, m_level);
        chk("empty", {31'd0, empty}, {31'd0, m_level == 0});
        chk("full", {31'd0, full}, {31'd0, m_level == DEPTH});
        chk("busy", {31'd0, busy}, {31'd0, m_wait});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int nxt;
        int dly;
        int cycles;
        int sent0;

        // T1 reset with write asserted
        rst_n = 1'b0;
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_level", {27'd0, level}, 32'd0);
        rst_n = 1'b1;

        // T2 single byte
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2_pulse", {31'd0, transmit}, 32'd1);
        chk("t2_dr", {24'd0, dr}, 32'hA5);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        idle(4);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // T3 ordering with launches two cycles after each done
        cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        idle(2);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            idle(3);
        end
        chk("t3_empty", {31'd0, empty}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_last", {24'd0, dr}, 32'h03);

        // T4 fill with frontend stalled, then overflow handling
        for (int k = 0; k < 17; k++) cyc(1'b1, 8'h40 + k[7:0], 1'b0, 1'b0, 1'b0);
        chk("t4_full", {31'd0, full}, 32'd1);
        chk("t4_level", {27'd0, level}, 32'd16);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        cyc(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
        chk("t4_ovf_wins", {31'd0, overflow}, 32'd1);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            idle(2);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t4_drained", {31'd0, empty}, 32'd1);

        // T5 flush while a frame is in flight
        for (int k = 0; k < 4; k++) cyc(1'b1, 8'h80 + k[7:0], 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_level", {27'd0, level}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t5_discard", {27'd0, level}, 32'd0);
        chk("t5_no_ovf", {31'd0, overflow}, 32'd0);

        // T6 wrap: 3*DEPTH bytes with random done latency and overlapping push/pop
        nxt = 0; dly = 0; cycles = 0; sent0 = tx_count;
        while (((tx_count - sent0) < 3 * DEPTH || m_wait) && cycles < 3000) begin
            logic w;
            logic dn;
            w  = (nxt < 3 * DEPTH) && (m_level < DEPTH) && ($urandom_range(0, 2) != 0);
            dn = 1'b0;
            if (m_wait) begin
                if (dly == 0) begin
                    dn  = 1'b1;
                    dly = $urandom_range(0, 4);
                end else begin
                    dly--;
                end
            end
            cyc(w, nxt[7:0], 1'b0, 1'b0, dn);
            if (w) nxt++;
            cycles++;
        end
        chk("t6_timeout", {31'd0, cycles < 3000}, 32'd1);
        chk("t6_count", tx_count - sent0, 3 * DEPTH);
        chk("t6_last", {24'd0, dr}, 32'h2F);
        chk("t6_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
